// File: rtl/tlb_request_arbiter.sv
// tlb_request_arbiter: shares the TLB lookup port between data write, data read and code prefetch; define TLB_ARB_CODE_AGING_EN to stop code starving behind data traffic
module tlb_request_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        pr_reset,
    input  logic        tlbwrite_do,
    input  logic [31:0] tlbwrite_address,
    input  logic [1:0]  tlbwrite_cpl,
    input  logic        tlbread_do,
    input  logic [31:0] tlbread_address,
    input  logic [1:0]  tlbread_cpl,
    input  logic        tlbcoderequest_do,
    input  logic [31:0] tlbcoderequest_address,
    input  logic        tlbcoderequest_su,
    output logic        tlbreq_do,
    output logic [31:0] tlbreq_address,
    output logic        tlbreq_su,
    output logic        tlbreq_rw,
    output logic        tlbreq_code,
    input  logic        tlbresp_done,
    output logic        tlbwrite_done,
    output logic        tlbread_done,
    output logic        tlbcode_do
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_WRITE = 2'd1;
    localparam logic [1:0] G_READ  = 2'd2;
    localparam logic [1:0] G_CODE  = 2'd3;
    logic [1:0] state;
    logic [1:0] grant;
    logic [1:0] win;
    logic       code_req;
    logic       code_first;
    logic       resp_ok;
    assign code_req = tlbcoderequest_do & ~pr_reset;
`ifdef TLB_ARB_CODE_AGING_EN
    logic [1:0] age;
    assign code_first = code_req & (age == 2'd3);
    // Count data grants that overtake a live code request; any break in the code request restarts the count
    always_ff @(posedge clk or posedge rst)
        if (rst) age <= 2'd0;
        else if (!code_req || (state == IDLE && win == G_CODE)) age <= 2'd0;
        else if (state == IDLE && win != G_NONE) age <= age + 2'd1;
`else
    assign code_first = 1'b0;
`endif
    // Winner of this cycle's arbitration: aged code, then write > read > code
    always_comb win = code_first ? G_CODE : tlbwrite_do ? G_WRITE : tlbread_do ? G_READ : code_req ? G_CODE : G_NONE;
    // Sequence the TLB port and latch the winning request's fields for the whole transaction
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= IDLE;
            grant          <= G_NONE;
            tlbreq_address <= 32'd0;
            tlbreq_su      <= 1'b0;
            tlbreq_rw      <= 1'b0;
            tlbreq_code    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win != G_NONE) begin
                    state          <= BUSY;
                    grant          <= win;
                    tlbreq_address <= (win == G_WRITE) ? tlbwrite_address : (win == G_READ) ? tlbread_address : tlbcoderequest_address;
                    tlbreq_su      <= (win == G_WRITE) ? (tlbwrite_cpl != 2'd3) : (win == G_READ) ? (tlbread_cpl != 2'd3) : tlbcoderequest_su;
                    tlbreq_rw      <= win == G_WRITE;
                    tlbreq_code    <= win == G_CODE;
                end
                BUSY: if (tlbresp_done) state <= IDLE;
                      else if (grant == G_CODE && (pr_reset || !tlbcoderequest_do)) state <= DRAIN;
                DRAIN: if (tlbresp_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    assign tlbreq_do     = state != IDLE;
    assign resp_ok       = (state == BUSY) & tlbresp_done;
    assign tlbwrite_done = resp_ok & (grant == G_WRITE);
    assign tlbread_done  = resp_ok & (grant == G_READ);
    assign tlbcode_do    = resp_ok & (grant == G_CODE) & ~pr_reset;
endmodule

// File: tb/tb_tlb_request_arbiter.sv
// tb_tlb_request_arbiter: directed scenarios plus random traffic against a transaction-level model of the arbiter
module tb_tlb_request_arbiter;
`ifdef TLB_ARB_CODE_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pr_reset = 1'b0;
    logic        tlbwrite_do = 1'b0;
    logic [31:0] tlbwrite_address = 32'd0;
    logic [1:0]  tlbwrite_cpl = 2'd0;
    logic        tlbread_do = 1'b0;
    logic [31:0] tlbread_address = 32'd0;
    logic [1:0]  tlbread_cpl = 2'd0;
    logic        tlbcoderequest_do = 1'b0;
    logic [31:0] tlbcoderequest_address = 32'd0;
    logic        tlbcoderequest_su = 1'b0;
    logic        tlbreq_do;
    logic [31:0] tlbreq_address;
    logic        tlbreq_su;
    logic        tlbreq_rw;
    logic        tlbreq_code;
    logic        tlbresp_done = 1'b0;
    logic        tlbwrite_done;
    logic        tlbread_done;
    logic        tlbcode_do;
    int n_cmp = 0;
    int n_bad = 0;
    // model: who owns the port (-1 none, 0 write, 1 read, 2 code), whether the owner was aborted, and data grants that overtook code
    int          owner = -1;
    bit          doomed = 1'b0;
    int          skipped = 0;
    logic [31:0] m_addr = 32'd0;
    bit          m_su = 1'b0;
    bit          m_rw = 1'b0;
    bit          m_code = 1'b0;
    bit          saw_w = 1'b0;
    bit          saw_r = 1'b0;
    bit          saw_c = 1'b0;

    always #5 clk = ~clk;

    tlb_request_arbiter dut (
        .clk(clk), .rst(rst), .pr_reset(pr_reset),
        .tlbwrite_do(tlbwrite_do), .tlbwrite_address(tlbwrite_address), .tlbwrite_cpl(tlbwrite_cpl),
        .tlbread_do(tlbread_do), .tlbread_address(tlbread_address), .tlbread_cpl(tlbread_cpl),
        .tlbcoderequest_do(tlbcoderequest_do), .tlbcoderequest_address(tlbcoderequest_address),
        .tlbcoderequest_su(tlbcoderequest_su),
        .tlbreq_do(tlbreq_do), .tlbreq_address(tlbreq_address), .tlbreq_su(tlbreq_su),
        .tlbreq_rw(tlbreq_rw), .tlbreq_code(tlbreq_code), .tlbresp_done(tlbresp_done),
        .tlbwrite_done(tlbwrite_done), .tlbread_done(tlbread_done), .tlbcode_do(tlbcode_do)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Compare every cycle against the model, then advance the model across the coming edge
    always @(negedge clk) begin : compare
        bit ew, er, ec, live;
        int pick;
        if (rst) begin
            chk1("rst_req_do", tlbreq_do, 1'b0);
            chk32("rst_address", tlbreq_address, 32'd0);
            chk1("rst_su", tlbreq_su, 1'b0);
            chk1("rst_rw", tlbreq_rw, 1'b0);
            chk1("rst_code", tlbreq_code, 1'b0);
            chk1("rst_write_done", tlbwrite_done, 1'b0);
            chk1("rst_read_done", tlbread_done, 1'b0);
            chk1("rst_code_do", tlbcode_do, 1'b0);
            owner = -1; doomed = 1'b0; skipped = 0;
            m_addr = 32'd0; m_su = 1'b0; m_rw = 1'b0; m_code = 1'b0;
            saw_w = 1'b0; saw_r = 1'b0; saw_c = 1'b0;
        end else begin
            ew = owner == 0 && tlbresp_done;
            er = owner == 1 && tlbresp_done;
            ec = owner == 2 && !doomed && tlbresp_done && !pr_reset;
            chk1("req_do", tlbreq_do, owner != -1);
            chk32("req_address", tlbreq_address, m_addr);
            chk1("req_su", tlbreq_su, m_su);
            chk1("req_rw", tlbreq_rw, m_rw);
            chk1("req_code", tlbreq_code, m_code);
            chk1("write_done", tlbwrite_done, ew);
            chk1("read_done", tlbread_done, er);
            chk1("code_do", tlbcode_do, ec);
            saw_w = ew; saw_r = er; saw_c = ec;
            live = tlbcoderequest_do && !pr_reset;
            pick = -1;
            if (owner == -1) begin
                pick = (AGING && skipped >= 3 && live) ? 2 : tlbwrite_do ? 0 : tlbread_do ? 1 : live ? 2 : -1;
                owner = pick;
                if (pick == 0) begin m_addr = tlbwrite_address; m_su = tlbwrite_cpl != 2'd3; end
                else if (pick == 1) begin m_addr = tlbread_address; m_su = tlbread_cpl != 2'd3; end
                else if (pick == 2) begin m_addr = tlbcoderequest_address; m_su = tlbcoderequest_su; end
                if (pick != -1) begin m_rw = pick == 0; m_code = pick == 2; end
            end else if (tlbresp_done) begin
                owner = -1;
                doomed = 1'b0;
            end else if (owner == 2 && (pr_reset || !tlbcoderequest_do)) doomed = 1'b1;
            skipped = !live ? 0 : pick == 2 ? 0 : pick >= 0 ? skipped + 1 : skipped;
        end
    end

    // Wait for a grant, answer it after lat cycles and check the routing and the idle gap that follows
    task automatic serve_one(input int lat, input int exp_who, input bit drop, output int who);
        int t = 0;
        while (!tlbreq_do && t < 50) begin nxt(); t++; end
        chk1("serve_grant", tlbreq_do, 1'b1);
        who = tlbreq_code ? 2 : tlbreq_rw ? 0 : 1;
        chk32("grant_order", 32'(who), 32'(exp_who));
        repeat (lat) nxt();
        tlbresp_done = 1'b1;
        @(negedge clk);
        chk32("done_route", {29'd0, tlbwrite_done, tlbread_done, tlbcode_do}, 32'(3'b100 >> exp_who));
        nxt();
        tlbresp_done = 1'b0;
        if (drop) begin
            if (who == 0) tlbwrite_do = 1'b0;
            else if (who == 1) tlbread_do = 1'b0;
            else tlbcoderequest_do = 1'b0;
        end
        @(negedge clk);
        chk1("idle_gap", tlbreq_do, 1'b0);
        nxt();
    endtask

    initial begin
        int w;
        logic [7:0] seq_act;
        logic [7:0] seq_exp;
        nxt(); nxt();
        chk1("reset_req_do", tlbreq_do, 1'b0);
        chk32("reset_address", tlbreq_address, 32'd0);
        rst = 1'b0;
        nxt();
        // single code request
        tlbcoderequest_do = 1'b1; tlbcoderequest_address = 32'h0000_1FF0; tlbcoderequest_su = 1'b1;
        @(negedge clk); chk1("t1_not_yet", tlbreq_do, 1'b0);
        nxt();
        @(negedge clk);
        chk1("t1_req_do", tlbreq_do, 1'b1);
        chk32("t1_address", tlbreq_address, 32'h0000_1FF0);
        chk1("t1_su", tlbreq_su, 1'b1);
        chk1("t1_code", tlbreq_code, 1'b1);
        chk1("t1_rw", tlbreq_rw, 1'b0);
        nxt(); nxt(); nxt();
        tlbresp_done = 1'b1;
        @(negedge clk);
        chk1("t1_code_do", tlbcode_do, 1'b1);
        chk1("t1_no_read_done", tlbread_done, 1'b0);
        nxt();
        tlbresp_done = 1'b0; tlbcoderequest_do = 1'b0;
        @(negedge clk);
        chk1("t1_idle", tlbreq_do, 1'b0);
        chk1("t1_single_pulse", tlbcode_do, 1'b0);
        nxt();
        // all three at once: write, read, code
        tlbwrite_do = 1'b1; tlbwrite_address = 32'hA000_0004; tlbwrite_cpl = 2'd3;
        tlbread_do = 1'b1; tlbread_address = 32'hB000_0008; tlbread_cpl = 2'd0;
        tlbcoderequest_do = 1'b1; tlbcoderequest_address = 32'hC000_0010; tlbcoderequest_su = 1'b0;
        serve_one(1, 0, 1'b1, w);
        serve_one(2, 1, 1'b1, w);
        serve_one(0, 2, 1'b1, w);
        // code aborted by pr_reset, drained, then a pending read
        tlbcoderequest_do = 1'b1; tlbcoderequest_address = 32'h0000_5000; tlbcoderequest_su = 1'b0;
        nxt();
        tlbread_do = 1'b1; tlbread_address = 32'h0000_6000; tlbread_cpl = 2'd1; pr_reset = 1'b1;
        @(negedge clk); chk1("t3_flush_code_do", tlbcode_do, 1'b0);
        nxt();
        pr_reset = 1'b0; tlbcoderequest_do = 1'b0;
        @(negedge clk);
        chk1("t3_drain_req_do", tlbreq_do, 1'b1);
        chk1("t3_drain_code_do", tlbcode_do, 1'b0);
        nxt();
        tlbresp_done = 1'b1;
        @(negedge clk);
        chk1("t3_swallow_code_do", tlbcode_do, 1'b0);
        chk1("t3_swallow_read_done", tlbread_done, 1'b0);
        nxt();
        tlbresp_done = 1'b0;
        @(negedge clk); chk1("t3_idle", tlbreq_do, 1'b0);
        nxt();
        @(negedge clk);
        chk1("t3_read_req_do", tlbreq_do, 1'b1);
        chk1("t3_read_code", tlbreq_code, 1'b0);
        chk32("t3_read_address", tlbreq_address, 32'h0000_6000);
        nxt();
        tlbresp_done = 1'b1;
        @(negedge clk); chk1("t3_read_done", tlbread_done, 1'b1);
        nxt();
        tlbresp_done = 1'b0; tlbread_do = 1'b0;
        nxt();
        // done and pr_reset together on a code grant
        tlbcoderequest_do = 1'b1; tlbcoderequest_address = 32'h0000_7000;
        nxt();
        tlbresp_done = 1'b1; pr_reset = 1'b1;
        @(negedge clk);
        chk1("t4_req_do", tlbreq_do, 1'b1);
        chk1("t4_code_do", tlbcode_do, 1'b0);
        nxt();
        tlbresp_done = 1'b0; pr_reset = 1'b0; tlbcoderequest_do = 1'b0;
        @(negedge clk); chk1("t4_idle", tlbreq_do, 1'b0);
        nxt();
        // reset in the middle of a write
        tlbwrite_do = 1'b1; tlbwrite_address = 32'hDEAD_BEE0; tlbwrite_cpl = 2'd0;
        nxt(); nxt();
        chk1("t5_busy", tlbreq_do, 1'b1);
        rst = 1'b1; tlbwrite_do = 1'b0;
        #1;
        chk1("t5_rst_req_do", tlbreq_do, 1'b0);
        chk32("t5_rst_address", tlbreq_address, 32'd0);
        chk1("t5_rst_rw", tlbreq_rw, 1'b0);
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t5_no_write_done", tlbwrite_done, 1'b0);
            chk1("t5_no_req", tlbreq_do, 1'b0);
            nxt();
        end
        // code and read held continuously
        rst = 1'b1; nxt(); rst = 1'b0;
        tlbread_do = 1'b1; tlbread_address = 32'h0000_3000; tlbread_cpl = 2'd3;
        tlbcoderequest_do = 1'b1; tlbcoderequest_address = 32'h0000_4000; tlbcoderequest_su = 1'b1;
        seq_act = 8'd0;
        seq_exp = 8'd0;
        for (int i = 0; i < 8; i++) begin
            seq_exp[i] = AGING && (i % 4 == 3);
            serve_one(1, seq_exp[i] ? 2 : 1, 1'b0, w);
            seq_act[i] = w == 2;
        end
        chk32("aging_order", {24'd0, seq_act}, {24'd0, seq_exp});
        rst = 1'b1; tlbread_do = 1'b0; tlbcoderequest_do = 1'b0;
        nxt();
        rst = 1'b0;
        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (saw_w) tlbwrite_do = 1'b0;
            else if (!tlbwrite_do && $urandom_range(3) == 0) begin
                tlbwrite_do = 1'b1; tlbwrite_address = $urandom; tlbwrite_cpl = 2'($urandom_range(3));
            end
            if (saw_r) tlbread_do = 1'b0;
            else if (!tlbread_do && $urandom_range(3) == 0) begin
                tlbread_do = 1'b1; tlbread_address = $urandom; tlbread_cpl = 2'($urandom_range(3));
            end
            if (saw_c || pr_reset || (tlbcoderequest_do && $urandom_range(40) == 0)) tlbcoderequest_do = 1'b0;
            else if (!tlbcoderequest_do && $urandom_range(2) == 0) begin
                tlbcoderequest_do = 1'b1; tlbcoderequest_address = $urandom; tlbcoderequest_su = 1'($urandom_range(1));
            end
            pr_reset = $urandom_range(12) == 0;
            tlbresp_done = owner != -1 && $urandom_range(2) == 0;
            nxt();
        end
        tlbresp_done = 1'b0; pr_reset = 1'b0;
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
